cb_monitor: RTL and testbench

- Hardware response checker for the 4-bit up/down loadable counter `cb`. It sits on the far side of the counter's interface: it snoops the same control bus the stimulus drives, plus the counter output.
- It runs a cycle-accurate shadow model of the counter and compares that model against `cnt_qout` every cycle.
- It counts mismatches and captures the first failure, so on-chip and bench self-checking need no expected-value file.

---
 rtl/cb_pkg.sv | 29 ++
 rtl/cb_model.sv | 41 ++++
 rtl/cb_monitor.sv | 117 +++++++++++
 tb/tb_cb_monitor.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cb_pkg.sv
// Shared definitions for the cb counter family: default width, monitor
// state encoding and the packed control-vector layout used by vector files.
package cb_pkg;

  localparam int CB_WIDTH = 4;

  typedef enum logic [1:0] {
    S_UNSYNC = 2'd0,
    S_TRACK  = 2'd1,
    S_HALT   = 2'd2
  } state_t;

  // Control vector, MSB first: {sclr, aset, din, load, dir, ena}
  typedef struct packed {
    logic                sclr;
    logic                aset;
    logic [CB_WIDTH-1:0] din;
    logic                load;
    logic                dir;
    logic                ena;
  } ctrl_t;

  // Any of these puts the counter into a known value regardless of history
  function automatic logic is_defining(input logic aset, input logic sclr,
                                       input logic load);
    return aset | sclr | load;
  endfunction

endpackage

// File: rtl/cb_model.sv
// Shadow model of the cb up/down loadable counter. Registered, modulo
// 2^WIDTH, with a freeze input so a host can stop it from tracking.
module cb_model
  import cb_pkg::*;
#(
  parameter int WIDTH = CB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             aset,
  input  logic             sclr,
  input  logic             load,
  input  logic             ena,
  input  logic             dir,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  // Priority update: aset > sclr > load > count up/down > hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (!freeze) begin
      if (aset) begin
        q <= '1;
      end else if (sclr) begin
        q <= '0;
      end else if (load) begin
        q <= din;
      end else if (ena) begin
        if (dir) begin
          q <= q + 1'b1;
        end else begin
          q <= q - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cb_monitor.sv
// Response checker for the cb counter: runs the shadow model, compares it
// against the counter output each cycle and records the first failure.
module cb_monitor
  import cb_pkg::*;
#(
  parameter int WIDTH       = CB_WIDTH,
  parameter int ERR_W       = 8,
  parameter int IDX_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             mon_en,
  input  logic             ena,
  input  logic             aset,
  input  logic             sclr,
  input  logic             load,
  input  logic             dir,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] cnt_qout,
  output logic [WIDTH-1:0] exp_q,
  output logic             synced,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [IDX_W-1:0] first_idx,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got,
  output logic             halted
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             model_freeze;
  logic             compare;
  logic             mismatch;

  // The counter output at this edge reflects controls of the previous edge,
  // which is exactly what exp_q holds until this edge updates it.
  assign model_freeze = (state == S_HALT);
  assign compare      = (state == S_TRACK) && mon_en;
  assign mismatch     = compare && (cnt_qout != exp_q);

  cb_model #(
    .WIDTH(WIDTH)
  ) u_model (
    .clk   (clk),
    .rst_n (aclr_n),
    .freeze(model_freeze),
    .aset  (aset),
    .sclr  (sclr),
    .load  (load),
    .ena   (ena),
    .dir   (dir),
    .din   (din),
    .q     (exp_q)
  );

  // Sync/track/halt control; synced and halted are registered with the state
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state  <= S_UNSYNC;
      synced <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_UNSYNC: begin
          if (is_defining(aset, sclr, load)) begin
            state  <= S_TRACK;
            synced <= 1'b1;
          end
        end
        S_TRACK: begin
          if (mismatch && STOP_ON_ERR) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state  <= S_UNSYNC;
          synced <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Error pulse, saturating count, first-failure capture and cycle index
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      err       <= 1'b0;
      err_cnt   <= '0;
      first_idx <= '0;
      first_exp <= '0;
      first_got <= '0;
      idx       <= '0;
    end else begin
      err <= mismatch;
      if (mismatch) begin
        if (err_cnt != {ERR_W{1'b1}}) begin
          err_cnt <= err_cnt + 1'b1;
        end
        if (err_cnt == '0) begin
          first_idx <= idx;
          first_exp <= exp_q;
          first_got <= cnt_qout;
        end
      end
      if (compare) begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cb_monitor.sv
// Directed bench for cb_monitor: two instances (keep-checking and
// stop-on-error) fed from one control bus, checked against a scoreboard.
module tb_cb_monitor;
  import cb_pkg::*;

  logic       clk = 1'b0;
  logic       aclr_n;
  logic       mon_en;
  ctrl_t      ctl;
  logic [3:0] cnt_qout;

  logic [3:0]  a_exp_q, a_first_exp, a_first_got;
  logic        a_synced, a_err, a_halted;
  logic [7:0]  a_err_cnt;
  logic [15:0] a_first_idx;
  logic [3:0]  b_exp_q, b_first_exp, b_first_got;
  logic        b_synced, b_err, b_halted;
  logic [7:0]  b_err_cnt;
  logic [15:0] b_first_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] exp;
    bit         synced;
    bit         err;
    bit         halted;
    int         ecnt;
    int         idx;
    int         fidx;
    logic [3:0] fexp;
    logic [3:0] fgot;
    int         st;
  } mdl_t;

  typedef struct {
    mdl_t a;
    mdl_t b;
  } pair_t;

  mdl_t  ma, mb;
  pair_t sb[$];

  always #5 clk = ~clk;

  cb_monitor #(.WIDTH(4), .ERR_W(8), .IDX_W(16), .STOP_ON_ERR(1'b0)) u_dut (
    .clk(clk), .aclr_n(aclr_n), .mon_en(mon_en), .ena(ctl.ena), .aset(ctl.aset),
    .sclr(ctl.sclr), .load(ctl.load), .dir(ctl.dir), .din(ctl.din),
    .cnt_qout(cnt_qout), .exp_q(a_exp_q), .synced(a_synced), .err(a_err),
    .err_cnt(a_err_cnt), .first_idx(a_first_idx), .first_exp(a_first_exp),
    .first_got(a_first_got), .halted(a_halted)
  );

  cb_monitor #(.WIDTH(4), .ERR_W(8), .IDX_W(16), .STOP_ON_ERR(1'b1)) u_halt (
    .clk(clk), .aclr_n(aclr_n), .mon_en(mon_en), .ena(ctl.ena), .aset(ctl.aset),
    .sclr(ctl.sclr), .load(ctl.load), .dir(ctl.dir), .din(ctl.din),
    .cnt_qout(cnt_qout), .exp_q(b_exp_q), .synced(b_synced), .err(b_err),
    .err_cnt(b_err_cnt), .first_idx(b_first_idx), .first_exp(b_first_exp),
    .first_got(b_first_got), .halted(b_halted)
  );

  function automatic mdl_t mzero();
    mdl_t m;
    m.exp = 4'h0; m.synced = 0; m.err = 0; m.halted = 0; m.ecnt = 0;
    m.idx = 0; m.fidx = 0; m.fexp = 4'h0; m.fgot = 4'h0; m.st = 0;
    return m;
  endfunction

  function automatic ctrl_t mk(bit sclr, bit aset, bit load, bit dir, bit ena,
                               logic [3:0] din);
    ctrl_t c;
    c.sclr = sclr; c.aset = aset; c.load = load; c.dir = dir; c.ena = ena;
    c.din = din;
    return c;
  endfunction

  // Reference behaviour of one monitor for one rising edge
  function automatic mdl_t step(mdl_t m, ctrl_t c, bit en, logic [3:0] got,
                                bit stop);
    mdl_t n = m;
    bit   cmp_now = (m.st == 1) && en;
    bit   bad     = cmp_now && (got != m.exp);
    if (m.st != 2) begin
      if (c.aset)      n.exp = 4'hF;
      else if (c.sclr) n.exp = 4'h0;
      else if (c.load) n.exp = c.din;
      else if (c.ena)  n.exp = c.dir ? m.exp + 4'd1 : m.exp - 4'd1;
    end
    n.err = bad;
    if (bad) begin
      if (m.ecnt == 0) begin
        n.fidx = m.idx; n.fexp = m.exp; n.fgot = got;
      end
      if (m.ecnt < 255) n.ecnt = m.ecnt + 1;
    end
    if (cmp_now) n.idx = (m.idx + 1) % 65536;
    if (m.st == 0 && (c.aset || c.sclr || c.load)) n.st = 1;
    else if (m.st == 1 && bad && stop) n.st = 2;
    n.synced = (n.st != 0);
    n.halted = (n.st == 2);
    return n;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    pair_t p;
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    p = sb.pop_front();
    cmp("a.exp_q",     a_exp_q,     p.a.exp);
    cmp("a.synced",    a_synced,    p.a.synced);
    cmp("a.err",       a_err,       p.a.err);
    cmp("a.err_cnt",   a_err_cnt,   p.a.ecnt);
    cmp("a.first_idx", a_first_idx, p.a.fidx);
    cmp("a.first_exp", a_first_exp, p.a.fexp);
    cmp("a.first_got", a_first_got, p.a.fgot);
    cmp("a.halted",    a_halted,    p.a.halted);
    cmp("b.exp_q",     b_exp_q,     p.b.exp);
    cmp("b.synced",    b_synced,    p.b.synced);
    cmp("b.err",       b_err,       p.b.err);
    cmp("b.err_cnt",   b_err_cnt,   p.b.ecnt);
    cmp("b.first_idx", b_first_idx, p.b.fidx);
    cmp("b.first_exp", b_first_exp, p.b.fexp);
    cmp("b.first_got", b_first_got, p.b.fgot);
    cmp("b.halted",    b_halted,    p.b.halted);
  endtask

  // One clock of stimulus; cnt_qout is a correct counter unless injected
  task automatic applyStimulus(input ctrl_t c, input bit en, input bit inj,
                               input logic [3:0] inj_val);
    @(negedge clk);
    ctl      = c;
    mon_en   = en;
    cnt_qout = inj ? inj_val : ma.exp;
    ma = step(ma, c, en, cnt_qout, 1'b0);
    mb = step(mb, c, en, cnt_qout, 1'b1);
    sb.push_back('{a: ma, b: mb});
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Asynchronous clear, checked before any clock edge arrives
  task automatic doReset();
    @(negedge clk);
    aclr_n = 1'b0;
    #1;
    ma = mzero();
    mb = mzero();
    sb.push_back('{a: ma, b: mb});
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    aclr_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    ctrl_t      up, down, hold;
    logic [3:0] down_seq [5];
    logic [3:0] bad_val;
    up   = mk(0, 0, 0, 1, 1, 4'h0);
    down = mk(0, 0, 0, 0, 1, 4'h0);
    hold = mk(0, 0, 0, 0, 0, 4'h0);
    down_seq = '{4'h2, 4'h1, 4'h0, 4'hF, 4'hE};

    aclr_n   = 1'b0;
    mon_en   = 1'b1;
    ctl      = hold;
    cnt_qout = 4'h0;
    ma = mzero();
    mb = mzero();
    $display("[TB] start");

    doReset();
    cmp("reset_exp_q", a_exp_q, 32'h0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(up, 1'b1, 1'b0, 4'h0);
      cmp("unsync_synced", a_synced, 32'h0);
      cmp("unsync_err", a_err, 32'h0);
    end

    applyStimulus(mk(1, 0, 0, 0, 0, 4'h0), 1'b1, 1'b0, 4'h0);
    cmp("sclr_exp_q", a_exp_q, 32'h0);
    cmp("sclr_synced", a_synced, 32'h1);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(up, 1'b1, 1'b0, 4'h0);
      cmp("up_walk_exp_q", a_exp_q, (i + 1) % 16);
      cmp("up_walk_err_cnt", a_err_cnt, 32'h0);
    end

    applyStimulus(mk(0, 0, 1, 0, 0, 4'h3), 1'b1, 1'b0, 4'h0);
    cmp("load_exp_q", a_exp_q, 32'h3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(down, 1'b1, 1'b0, 4'h0);
      cmp("down_exp_q", a_exp_q, down_seq[i]);
    end

    for (int i = 0; i < 2; i++) begin
      applyStimulus(up, 1'b0, 1'b1, 4'hA);
      cmp("mon_en_low_err", a_err, 32'h0);
    end

    applyStimulus(mk(1, 1, 1, 0, 0, 4'h5), 1'b1, 1'b0, 4'h0);
    cmp("aset_prio_exp_q", a_exp_q, 32'hF);
    applyStimulus(hold, 1'b1, 1'b0, 4'h0);
    cmp("aset_prio_err", a_err, 32'h0);

    doReset();
    cmp("midrun_reset_synced", a_synced, 32'h0);

    applyStimulus(mk(1, 0, 0, 0, 0, 4'h0), 1'b1, 1'b0, 4'h0);
    applyStimulus(up, 1'b1, 1'b0, 4'h0);
    applyStimulus(up, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 7; i++) applyStimulus(hold, 1'b1, 1'b0, 4'h0);
    cmp("pre_inject_exp_q", a_exp_q, 32'h2);

    applyStimulus(hold, 1'b1, 1'b1, 4'h7);
    cmp("inject_err", a_err, 32'h1);
    cmp("inject_err_cnt", a_err_cnt, 32'h1);
    cmp("inject_first_idx", a_first_idx, 32'd9);
    cmp("inject_first_exp", a_first_exp, 32'h2);
    cmp("inject_first_got", a_first_got, 32'h7);
    cmp("stop_halted", b_halted, 32'h1);

    applyStimulus(hold, 1'b1, 1'b0, 4'h0);
    cmp("err_one_cycle", a_err, 32'h0);

    applyStimulus(hold, 1'b1, 1'b1, 4'h8);
    cmp("second_err_cnt", a_err_cnt, 32'h2);
    cmp("second_first_idx", a_first_idx, 32'd9);
    cmp("second_first_got", a_first_got, 32'h7);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(up, 1'b1, 1'b0, 4'h0);
      cmp("halt_frozen_exp_q", b_exp_q, 32'h2);
      cmp("halt_no_err", b_err, 32'h0);
    end

    for (int i = 0; i < 260; i++) begin
      bad_val = ma.exp ^ 4'h1;
      applyStimulus(hold, 1'b1, 1'b1, bad_val);
    end
    cmp("saturated_err_cnt", a_err_cnt, 32'hFF);
    cmp("saturated_err", a_err, 32'h1);

    doReset();
    cmp("halt_reset_halted", b_halted, 32'h0);
    cmp("halt_reset_exp_q", b_exp_q, 32'h0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(up, 1'b1, 1'b1, 4'h9);
      cmp("post_reset_unsync", a_synced, 32'h0);
      cmp("post_reset_no_err", a_err, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
